// File: rtl/ru_fifo_nton.sv
`default_nettype none
// ============================================================================
//  Module      : ru_fifo_nton
//  Description : N-input / N-output routing unit. Each input word carries a
//                destination index and is buffered in the FIFO of that
//                output. Each output FIFO takes up to PORT_NUM writes per
//                cycle, chosen by a per-output round-robin scan, and drains
//                one word per cycle.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                in_valid/in_data/in_addr/in_ready
//                                    - per-input valid/ready word + address
//                out_valid/out_data/out_ready
//                                    - per-output FIFO head with pop request
//                out_count           - per-output FIFO occupancy
//                addr_err            - 1-cycle pulse on out-of-range address
//  Revision    : 1.0 - initial release
// ============================================================================
module ru_fifo_nton #(
    parameter int PORT_NUM   = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_WIDTH = 32,
    parameter int ADDR_W     = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORT_NUM-1:0]            in_valid,
    input  logic [PORT_NUM*FIFO_WIDTH-1:0] in_data,
    input  logic [PORT_NUM*ADDR_W-1:0]     in_addr,
    output logic [PORT_NUM-1:0]            in_ready,
    output logic [PORT_NUM-1:0]            out_valid,
    output logic [PORT_NUM*FIFO_WIDTH-1:0] out_data,
    input  logic [PORT_NUM-1:0]            out_ready,
    output logic [PORT_NUM*CNT_W-1:0]      out_count,
    output logic [PORT_NUM-1:0]            addr_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RR_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [RR_W-1:0]  c_LAST_IDX = RR_W'(PORT_NUM - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FIFO_WIDTH-1:0] r_mem    [PORT_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr [PORT_NUM];
    logic [PTR_W-1:0]      r_rd_ptr [PORT_NUM];
    logic [CNT_W-1:0]      r_count  [PORT_NUM];
    logic [RR_W-1:0]       r_rr_ptr [PORT_NUM];
    logic [PORT_NUM-1:0]   r_addr_err;

    // ------------------------------------------------------------------------
    // Combinational routing signals (first index = output, second = input)
    // ------------------------------------------------------------------------
    logic [PORT_NUM-1:0] w_bad;
    logic [PORT_NUM-1:0] w_req    [PORT_NUM];
    logic [PORT_NUM-1:0] w_gnt    [PORT_NUM];
    logic [PTR_W-1:0]    w_waddr  [PORT_NUM][PORT_NUM];
    logic [PTR_W-1:0]    w_wr_nxt [PORT_NUM];
    logic [CNT_W-1:0]    w_nwr    [PORT_NUM];
    logic [RR_W-1:0]     w_rr_nxt [PORT_NUM];
    logic [PORT_NUM-1:0] w_denied;
    logic [PORT_NUM-1:0] w_pop;

    // Address decode: out-of-range destinations are flagged and never
    // request any output.
    always_comb begin : p_decode
        logic [ADDR_W-1:0] v_addr;
        v_addr = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            v_addr   = in_addr[i*ADDR_W +: ADDR_W];
            w_bad[i] = in_valid[i] && ({1'b0, v_addr} >= (ADDR_W+1)'(PORT_NUM));
        end
        for (int j = 0; j < PORT_NUM; j++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                w_req[j][i] = in_valid[i] && !w_bad[i] &&
                              (in_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(j));
            end
        end
    end

    // Per-output grant scan. Starting at the round-robin pointer, requesters
    // are granted while free slots remain; each grant takes the next write
    // location so words land in scan order. Free room comes only from the
    // registered count, so a same-cycle pop never admits an extra word.
    always_comb begin : p_grant
        int                v_sum;
        logic [RR_W-1:0]   v_idx;
        logic [CNT_W-1:0]  v_free;
        logic [CNT_W-1:0]  v_nwr;
        logic [PTR_W-1:0]  v_wp;
        logic [RR_W-1:0]   v_rr;
        logic              v_den;
        logic [PORT_NUM-1:0] v_gnt;
        v_sum  = 0;
        v_idx  = '0;
        v_free = '0;
        v_nwr  = '0;
        v_wp   = '0;
        v_rr   = '0;
        v_den  = 1'b0;
        v_gnt  = '0;
        for (int j = 0; j < PORT_NUM; j++) begin
            v_free = c_DEPTH - r_count[j];
            v_nwr  = '0;
            v_wp   = r_wr_ptr[j];
            v_rr   = r_rr_ptr[j];
            v_den  = 1'b0;
            v_gnt  = '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                w_waddr[j][i] = '0;
            end
            for (int k = 0; k < PORT_NUM; k++) begin
                v_sum = int'(r_rr_ptr[j]) + k;
                if (v_sum >= PORT_NUM) begin
                    v_sum = v_sum - PORT_NUM;
                end
                v_idx = RR_W'(v_sum);
                if (w_req[j][v_idx]) begin
                    if (v_nwr < v_free) begin
                        v_gnt[v_idx]      = 1'b1;
                        w_waddr[j][v_idx] = v_wp;
                        v_wp  = (v_wp == c_LAST_PTR) ? '0 : v_wp + PTR_W'(1);
                        v_nwr = v_nwr + CNT_W'(1);
                        // Only used when some request is denied; with zero
                        // grants it still holds the current pointer.
                        v_rr  = (v_idx == c_LAST_IDX) ? '0 : v_idx + RR_W'(1);
                    end else begin
                        v_den = 1'b1;
                    end
                end
            end
            w_gnt[j]    = v_gnt;
            w_nwr[j]    = v_nwr;
            w_wr_nxt[j] = v_wp;
            w_rr_nxt[j] = v_rr;
            w_denied[j] = v_den;
        end
    end

    // Idle inputs and bad-address inputs are always ready; a valid input
    // with a legal address is ready only when its output granted it.
    always_comb begin : p_ready
        logic [PORT_NUM-1:0] v_rdy;
        v_rdy = ~in_valid | w_bad;
        for (int j = 0; j < PORT_NUM; j++) begin
            v_rdy = v_rdy | w_gnt[j];
        end
        in_ready = v_rdy;
    end

    assign w_pop = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Pointer / count / arbitration state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < PORT_NUM; j++) begin
                r_wr_ptr[j] <= '0;
                r_rd_ptr[j] <= '0;
                r_count[j]  <= '0;
                r_rr_ptr[j] <= '0;
            end
            r_addr_err <= '0;
        end else begin
            r_addr_err <= w_bad;
            for (int j = 0; j < PORT_NUM; j++) begin
                r_wr_ptr[j] <= w_wr_nxt[j];
                if (w_pop[j]) begin
                    r_rd_ptr[j] <= (r_rd_ptr[j] == c_LAST_PTR) ? '0
                                                               : r_rd_ptr[j] + PTR_W'(1);
                end
                r_count[j] <= r_count[j] + w_nwr[j] - CNT_W'(w_pop[j]);
                if (w_denied[j]) begin
                    r_rr_ptr[j] <= w_rr_nxt[j];
                end
            end
        end
    end

    // Storage is not reset; validity is tracked by the counts alone.
    always_ff @(posedge clk) begin
        for (int j = 0; j < PORT_NUM; j++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (w_gnt[j][i]) begin
                    r_mem[j][w_waddr[j][i]] <= in_data[i*FIFO_WIDTH +: FIFO_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    generate
        for (genvar j = 0; j < PORT_NUM; j++) begin : g_out
            assign out_valid[j]                           = (r_count[j] != '0);
            assign out_data[j*FIFO_WIDTH +: FIFO_WIDTH]   = r_mem[j][r_rd_ptr[j]];
            assign out_count[j*CNT_W +: CNT_W]            = r_count[j];
        end
    endgenerate

    assign addr_err = r_addr_err;

endmodule
`default_nettype wire
